// File: rtl/mem_sram_bank.sv
// Single-port SRAM bank with a valid/ready request port and a fixed-latency response strobe.
// The memory is zero-filled after every reset. Defining MEM_OUTREG_EN adds an output register stage, giving a latency of 2.
module mem_sram_bank #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wmask,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    init_done
);

  localparam int unsigned NBYTES = DATA_WIDTH / 8;
  localparam int unsigned OFF_W  = $clog2(NBYTES);
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned AW1    = ADDR_WIDTH + 1;

  typedef enum logic {ST_INIT, ST_IDLE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IDX_W-1:0]      r_clr_cnt;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_clr_en;
  logic                  w_accept;
  logic                  w_is_write;
  logic                  w_oor;
  logic [AW1-1:0]        w_word_idx;
  logic [IDX_W-1:0]      w_idx;

  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_err;

  // Extra zero bit keeps the range compare valid when DEPTH fills the whole address space.
  assign w_word_idx = {1'b0, req_addr} >> OFF_W;
  assign w_oor      = w_word_idx >= AW1'(DEPTH);
  assign w_idx      = IDX_W'(w_word_idx);
  assign w_is_write = |req_wmask;
  assign w_accept   = req_valid & req_ready;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_INIT;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: if (r_clr_cnt == IDX_W'(DEPTH - 1)) w_state_nxt = ST_IDLE;
      ST_IDLE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // Output decode
  always_comb begin
    req_ready = 1'b0;
    init_done = 1'b0;
    w_clr_en  = 1'b0;
    case (r_state)
      ST_INIT: w_clr_en = 1'b1;
      ST_IDLE: begin
        req_ready = 1'b1;
        init_done = 1'b1;
      end
      default: w_clr_en = 1'b0;
    endcase
  end

  // Clear counter; it wraps to zero on the last cleared word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      r_clr_cnt <= '0;
    else if (w_clr_en) r_clr_cnt <= r_clr_cnt + IDX_W'(1);
  end

  // Memory array: zero-fill during INIT, byte-masked writes in IDLE.
  always_ff @(posedge clk) begin
    if (w_clr_en) begin
      r_mem[r_clr_cnt] <= '0;
    end else if (w_accept && !w_oor && w_is_write) begin
      for (int k = 0; k < NBYTES; k++) begin
        if (req_wmask[k]) r_mem[w_idx][8*k +: 8] <= req_wdata[8*k +: 8];
      end
    end
  end

  // First response stage; data and err stay zero whenever valid is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= w_accept;
      r_rsp_err   <= w_accept & w_oor;
      r_rsp_rdata <= (w_accept && !w_oor && !w_is_write) ? r_mem[w_idx] : '0;
    end
  end

`ifdef MEM_OUTREG_EN
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_rdata;
  logic                  r_out_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_out_rdata <= '0;
      r_out_err   <= 1'b0;
    end else begin
      r_out_valid <= r_rsp_valid;
      r_out_rdata <= r_rsp_rdata;
      r_out_err   <= r_rsp_err;
    end
  end

  assign rsp_valid = r_out_valid;
  assign rsp_rdata = r_out_rdata;
  assign rsp_err   = r_out_err;
`else
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
`endif

endmodule

// File: doc/mem_sram_bank.md
MEM_SRAM_BANK -- requirements
Module: mem_sram_bank

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width in bits; multiple of 8, minimum 8.
REQ-002 SHALL have parameter DEPTH, default 256, number of words; power of two, minimum 2.
REQ-003 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_valid  input  1  request present.
REQ-007 SHALL have port req_ready  output  1  request accepted when req_valid and req_ready are both high at a clk edge.
REQ-008 SHALL have port req_addr  input  ADDR_WIDTH  byte address.
REQ-009 SHALL have port req_wdata  input  DATA_WIDTH  write data.
REQ-010 SHALL have port req_wmask  input  DATA_WIDTH/8  byte write enables; all zero means read.
REQ-011 SHALL have port rsp_valid  output  1  single-cycle response strobe.
REQ-012 SHALL have port rsp_rdata  output  DATA_WIDTH  read data; zero for writes and errors.
REQ-013 SHALL have port rsp_err  output  1  out-of-range access.
REQ-014 SHALL have port init_done  output  1  high once the post-reset clear has finished.

Function
REQ-015 SHALL compute word index = req_addr >> log2(DATA_WIDTH/8); low byte-offset bits ignored.
REQ-016 SHALL flag an access as out of range when word index >= DEPTH.
REQ-017 SHALL use FSM states INIT and IDLE; reset enters INIT.
REQ-018 In INIT, SHALL write zero to one word per cycle, clear counter 0..DEPTH-1, hold req_ready=0 and init_done=0.
REQ-019 After the write of word DEPTH-1, SHALL enter IDLE; init_done=1 and req_ready=1 from the first IDLE cycle, i.e. exactly DEPTH cycles after reset release.
REQ-020 In IDLE, req_ready SHALL be constantly 1; one request accepted per cycle, no backpressure; rsp_valid has no ready and is always consumed.
REQ-021 Read: rsp_valid=1 with rsp_rdata=mem[index], err=0, one cycle after acceptance (base latency 1).
REQ-022 Write: SHALL update only bytes whose mask bit is set; byte k = data bits [8k+7:8k]; rsp_valid=1, rdata=0, err=0 at base latency.
REQ-023 Out of range: SHALL perform no write; rsp_valid=1, rdata=0, err=1 at base latency.
REQ-024 A read accepted the cycle after a write to the same word SHALL return the written data.
REQ-025 rsp_valid SHALL be 0 on cycles with no response due; rsp_rdata and rsp_err SHALL be 0 whenever rsp_valid=0.
REQ-026 Back-to-back requests SHALL yield back-to-back responses in request order.

Reset
REQ-027 Assertion of reset_n SHALL immediately force req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0, clear counter=0, state=INIT.
REQ-028 Reset during operation SHALL discard all in-flight responses and restart the full clear; memory content is zero once init_done rises.

Configuration
REQ-029 Macro MEM_OUTREG_EN defined: one extra output register stage; every response latency becomes 2 cycles; throughput stays one per cycle; ordering and REQ-024 still hold.
REQ-030 MEM_OUTREG_EN undefined: latency 1 as in REQ-021..023.

Verification
REQ-031 Release reset, DEPTH=256 -> init_done and req_ready rise exactly 256 cycles later; reads of addresses 0x000, 0x3FC return 0.
REQ-032 Write 0xDEADBEEF to 0x10, mask 4'b1111; then write 0x11223344, mask 4'b0101; read 0x10 -> 0xDE22BE44, err=0.
REQ-033 Read address 0x400 (DEPTH=256, DATA_WIDTH=32) -> rsp_err=1, rdata=0; a following read of 0x000 shows no corruption.
REQ-034 Write 0xA5A5A5A5 to 0x20 then read 0x20 the next cycle -> 0xA5A5A5A5 with latency 1 (2 with MEM_OUTREG_EN).
REQ-035 Write 0xFFFFFFFF to 0x8, assert reset_n low mid-stream for 3 cycles -> outputs zero immediately, no stale rsp_valid; after re-init, read 0x8 returns 0.
REQ-036 DATA_WIDTH=64, DEPTH=16: write 0x0123456789ABCDEF to 0x18, mask 8'hF0; read -> 0x0123456700000000.
